// File: rtl/alu_nibble_seq_if.sv
// rtl/alu_nibble_seq_if.sv - bus between the nibble sequencer (master) and one 4-bit ALU slice (slave)
interface alu_nibble_seq_if;
  logic [3:0] slice_x;
  logic [3:0] slice_y;
  logic [5:0] slice_c;
  logic       slice_cin;
  logic [3:0] slice_out;
  logic       slice_cout;
  logic       slice_nz;

  modport master (
    output slice_x, slice_y, slice_c, slice_cin,
    input  slice_out, slice_cout, slice_nz
  );

  modport slave (
    input  slice_x, slice_y, slice_c, slice_cin,
    output slice_out, slice_cout, slice_nz
  );
endinterface

// File: rtl/alu_nibble_seq.sv
// rtl/alu_nibble_seq.sv - nibble-serial sequencer driving one 4-bit ALU slice, LSB nibble first
// ALU_SEQ_OVERFLOW_EN adds the signed-overflow output v_flag.
module alu_nibble_seq #(
  parameter int NIBBLES = 4
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   start,
  input  logic [5:0]             op,
  input  logic [4*NIBBLES-1:0]   x,
  input  logic [4*NIBBLES-1:0]   y,
  input  logic                   cin,
  alu_nibble_seq_if.master       sl,
  output logic                   busy,
  output logic                   done,
  output logic [4*NIBBLES-1:0]   result,
  output logic                   cout,
  output logic                   z_flag,
  output logic                   n_flag
`ifdef ALU_SEQ_OVERFLOW_EN
  ,
  output logic                   v_flag
`endif
);

  localparam int W  = 4 * NIBBLES;
  localparam int SW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;
  localparam logic [SW-1:0] LAST = SW'(NIBBLES - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         state_q, state_d;
  logic [SW-1:0]  step_q, step_d;
  logic [5:0]     op_q, op_d;
  logic [W-1:0]   x_q, x_d;
  logic [W-1:0]   y_q, y_d;
  logic           cin_q, cin_d;
  logic           carry_q, carry_d;
  logic           nz_q, nz_d;
  logic [W-1:0]   result_q, result_d;
  logic           cout_q, cout_d;
  logic           z_q, z_d;
  logic           n_q, n_d;
`ifdef ALU_SEQ_OVERFLOW_EN
  logic           v_q, v_d;
  logic           ax, ay;
`endif

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= S_IDLE;
      step_q   <= '0;
      op_q     <= '0;
      x_q      <= '0;
      y_q      <= '0;
      cin_q    <= 1'b0;
      carry_q  <= 1'b0;
      nz_q     <= 1'b0;
      result_q <= '0;
      cout_q   <= 1'b0;
      z_q      <= 1'b0;
      n_q      <= 1'b0;
`ifdef ALU_SEQ_OVERFLOW_EN
      v_q      <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      step_q   <= step_d;
      op_q     <= op_d;
      x_q      <= x_d;
      y_q      <= y_d;
      cin_q    <= cin_d;
      carry_q  <= carry_d;
      nz_q     <= nz_d;
      result_q <= result_d;
      cout_q   <= cout_d;
      z_q      <= z_d;
      n_q      <= n_d;
`ifdef ALU_SEQ_OVERFLOW_EN
      v_q      <= v_d;
`endif
    end
  end

`ifdef ALU_SEQ_OVERFLOW_EN
  // Effective operand sign bits after the slice's enable/negate stage
  assign ax = (op_q[5] & x_q[W-1]) ^ op_q[4];
  assign ay = (op_q[3] & y_q[W-1]) ^ op_q[2];
`endif

  always_comb begin
    state_d  = state_q;
    step_d   = step_q;
    op_d     = op_q;
    x_d      = x_q;
    y_d      = y_q;
    cin_d    = cin_q;
    carry_d  = carry_q;
    nz_d     = nz_q;
    result_d = result_q;
    cout_d   = cout_q;
    z_d      = z_q;
    n_d      = n_q;
`ifdef ALU_SEQ_OVERFLOW_EN
    v_d      = v_q;
`endif

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_RUN;
          op_d    = op;
          x_d     = x;
          y_d     = y;
          cin_d   = cin;
          step_d  = '0;
          nz_d    = 1'b0;
        end
      end
      S_RUN: begin
        result_d[{step_q, 2'b00} +: 4] = sl.slice_out;
        carry_d = sl.slice_cout;
        nz_d    = nz_q | sl.slice_nz;
        if (step_q == LAST) begin
          // Flags are captured with the last nibble so they are already valid while done is high
          state_d = S_DONE;
          step_d  = '0;
          cout_d  = sl.slice_cout;
          z_d     = ~(nz_q | sl.slice_nz);
          n_d     = sl.slice_out[3];
`ifdef ALU_SEQ_OVERFLOW_EN
          v_d     = op_q[1] & (ax == ay) & (sl.slice_out[3] != ax);
`endif
        end else begin
          step_d = step_q + SW'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // step_q is held at 0 outside RUN, so IDLE shows nibble 0 and the latched carry-in
  assign sl.slice_x   = x_q[{step_q, 2'b00} +: 4];
  assign sl.slice_y   = y_q[{step_q, 2'b00} +: 4];
  assign sl.slice_c   = op_q;
  assign sl.slice_cin = (state_q == S_RUN && step_q != '0) ? carry_q : cin_q;

  assign busy   = (state_q != S_IDLE);
  assign done   = (state_q == S_DONE);
  assign result = result_q;
  assign cout   = cout_q;
  assign z_flag = z_q;
  assign n_flag = n_q;
`ifdef ALU_SEQ_OVERFLOW_EN
  assign v_flag = v_q;
`endif

endmodule
